// File: rtl/io_wb_bridge.sv
// rtl/io_wb_bridge.sv - pipelined IO request to single-outstanding Wishbone B3 bridge
// Reads terminated by err or timeout return all-ones so an absent device never stalls the CPU.
module io_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] avm_address,
  input  logic [3:0]  avm_byteenable,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  output logic        avm_readdatavalid,
  output logic [31:0] avm_readdata,
  output logic [15:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_error_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;
  logic [15:0]   adr_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  logic          we_q, cyc_q;
  logic          rdv_q, berr_q;
  logic [31:0]  rdata_q;

  // cnt_d is the count including the current cycle, so a match ends the N-th cycle of cyc.
  always_comb begin
    cnt_d   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    timeout = (TIMEOUT_CYCLES != 0) && (cnt_d == T_LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdv_q   <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdv_q  <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Read and write together is taken as a write; the read is consumed.
          if (avm_read || avm_write) begin
            adr_q   <= avm_address;
            sel_q   <= avm_byteenable;
            dat_q   <= avm_writedata;
            we_q    <= avm_write;
            cnt_q   <= '0;
            cyc_q   <= 1'b1;
            state_q <= S_BUS;
          end
        end
        S_BUS: begin
          cnt_q <= cnt_d;
          if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_IDLE;
            if (!we_q) begin
              rdv_q   <= 1'b1;
              rdata_q <= wb_dat_i;
            end
          end else if (wb_err_i || timeout) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_IDLE;
            berr_q  <= 1'b1;
            if (!we_q) begin
              rdv_q   <= 1'b1;
              rdata_q <= 32'hFFFF_FFFF;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign avm_waitrequest   = !rst_n || (state_q == S_BUS);
  assign avm_readdatavalid = rdv_q;
  assign avm_readdata      = rdata_q;
  assign wb_adr_o          = adr_q;
  assign wb_sel_o          = sel_q;
  assign wb_dat_o          = dat_q;
  assign wb_we_o           = we_q;
  assign wb_cyc_o          = cyc_q;
  assign wb_stb_o          = cyc_q;
  assign bus_error_o       = berr_q;

endmodule

// File: tb/tb_io_wb_bridge.sv
// tb/tb_io_wb_bridge.sv - directed self-checking bench for io_wb_bridge
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_io_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic [15:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        bus_error_o;

  int total = 0;
  int bad   = 0;

  io_wb_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    avm_read = rd; avm_write = wr; avm_address = a; avm_byteenable = be; avm_writedata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick();
    tick();
    chk("wait_in_reset", {31'b0, avm_waitrequest}, 32'd1);
    rst_n = 1'b1;
    tick();
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'b0, wb_we_o}, 32'd0);
    chk("rst_rdv", {31'b0, avm_readdatavalid}, 32'd0);
    chk("rst_rdata", avm_readdata, 32'h0);
    chk("rst_adr", {16'b0, wb_adr_o}, 32'h0);
    chk("rst_sel", {28'b0, wb_sel_o}, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_berr", {31'b0, bus_error_o}, 32'd0);
    chk("rst_wait", {31'b0, avm_waitrequest}, 32'd0);

    // Spurious ack while idle
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_0000;
    tick();
    wb_ack_i = 1'b0;
    tick();
    chk("spur_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("spur_rdv", {31'b0, avm_readdatavalid}, 32'd0);

    // Write, ack in 2nd stb cycle
    req(1'b0, 1'b1, 16'h0060, 4'b0001, 32'h0000_00AB);
    chk("wr_t0_wait", {31'b0, avm_waitrequest}, 32'd0);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("wr_t1_cyc", {31'b0, wb_cyc_o}, 32'd1);
    chk("wr_t1_stb", {31'b0, wb_stb_o}, 32'd1);
    chk("wr_t1_we", {31'b0, wb_we_o}, 32'd1);
    chk("wr_t1_wait", {31'b0, avm_waitrequest}, 32'd1);
    chk("wr_adr", {16'b0, wb_adr_o}, 32'h0060);
    chk("wr_sel", {28'b0, wb_sel_o}, 32'h1);
    chk("wr_dat", wb_dat_o, 32'h0000_00AB);
    tick();
    chk("wr_t2_cyc", {31'b0, wb_cyc_o}, 32'd1);
    chk("wr_t2_wait", {31'b0, avm_waitrequest}, 32'd1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("wr_end_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("wr_end_we", {31'b0, wb_we_o}, 32'd0);
    chk("wr_end_rdv", {31'b0, avm_readdatavalid}, 32'd0);
    chk("wr_end_berr", {31'b0, bus_error_o}, 32'd0);
    chk("wr_hold_adr", {16'b0, wb_adr_o}, 32'h0060);
    tick();
    chk("wr_post_rdv", {31'b0, avm_readdatavalid}, 32'd0);

    // Zero-wait read
    req(1'b1, 1'b0, 16'h0070, 4'hF, 32'h0);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("rd_t1_cyc", {31'b0, wb_cyc_o}, 32'd1);
    chk("rd_t1_we", {31'b0, wb_we_o}, 32'd0);
    chk("rd_t1_adr", {16'b0, wb_adr_o}, 32'h0070);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    tick();
    wb_ack_i = 1'b0;
    chk("rd_t2_rdv", {31'b0, avm_readdatavalid}, 32'd1);
    chk("rd_t2_data", avm_readdata, 32'h1234_5678);
    chk("rd_t2_cyc", {31'b0, wb_cyc_o}, 32'd0);
    tick();
    chk("rd_t3_rdv", {31'b0, avm_readdatavalid}, 32'd0);

    // Back-to-back reads
    req(1'b1, 1'b0, 16'h0060, 4'hF, 32'h0);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1122_3344;
    tick();
    wb_ack_i = 1'b0;
    chk("b2b_rdv1", {31'b0, avm_readdatavalid}, 32'd1);
    chk("b2b_data1", avm_readdata, 32'h1122_3344);
    req(1'b1, 1'b0, 16'h0064, 4'hF, 32'h0);
    chk("b2b_accept", {31'b0, avm_waitrequest}, 32'd0);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("b2b_cyc2", {31'b0, wb_cyc_o}, 32'd1);
    chk("b2b_adr2", {16'b0, wb_adr_o}, 32'h0064);
    chk("b2b_gap_rdv", {31'b0, avm_readdatavalid}, 32'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h5566_7788;
    tick();
    wb_ack_i = 1'b0;
    chk("b2b_rdv2", {31'b0, avm_readdatavalid}, 32'd1);
    chk("b2b_data2", avm_readdata, 32'h5566_7788);
    tick();

    // Timeout: cyc high exactly 4 cycles, no ack
    req(1'b1, 1'b0, 16'h0300, 4'hF, 32'h0);
    wb_dat_i = 32'h0BAD_0BAD;
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_cyc%0d", i + 1), {31'b0, wb_cyc_o}, 32'd1);
      chk($sformatf("to_rdv%0d", i + 1), {31'b0, avm_readdatavalid}, 32'd0);
      tick();
    end
    chk("to_end_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("to_rdv", {31'b0, avm_readdatavalid}, 32'd1);
    chk("to_data", avm_readdata, 32'hFFFF_FFFF);
    chk("to_berr", {31'b0, bus_error_o}, 32'd1);
    tick();
    chk("to_berr_pulse", {31'b0, bus_error_o}, 32'd0);

    // Write terminated by err
    req(1'b0, 1'b1, 16'h0080, 4'b1100, 32'hA5A5_0000);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    wb_err_i = 1'b1;
    tick();
    wb_err_i = 1'b0;
    chk("err_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("err_berr", {31'b0, bus_error_o}, 32'd1);
    chk("err_rdv", {31'b0, avm_readdatavalid}, 32'd0);
    tick();
    chk("err_berr_pulse", {31'b0, bus_error_o}, 32'd0);

    // Read with ack and err together: ack wins
    req(1'b1, 1'b0, 16'h0084, 4'hF, 32'h0);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    chk("pri_rdv", {31'b0, avm_readdatavalid}, 32'd1);
    chk("pri_data", avm_readdata, 32'hCAFE_F00D);
    chk("pri_berr", {31'b0, bus_error_o}, 32'd0);
    tick();

    // Read and write together: treated as write, no readdatavalid
    req(1'b1, 1'b1, 16'h0088, 4'hF, 32'h0000_1234);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("rw_we", {31'b0, wb_we_o}, 32'd1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("rw_rdv", {31'b0, avm_readdatavalid}, 32'd0);
    chk("rw_cyc", {31'b0, wb_cyc_o}, 32'd0);
    tick();

    // Reset mid-BUS
    req(1'b1, 1'b0, 16'h0090, 4'hF, 32'h0);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("rmb_cyc_before", {31'b0, wb_cyc_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rmb_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rmb_stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rmb_wait", {31'b0, avm_waitrequest}, 32'd1);
    rst_n = 1'b1;
    tick();
    chk("rmb_rdv", {31'b0, avm_readdatavalid}, 32'd0);
    chk("rmb_idle_wait", {31'b0, avm_waitrequest}, 32'd0);
    req(1'b1, 1'b0, 16'h0094, 4'hF, 32'h0);
    tick();
    req(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("post_rst_adr", {16'b0, wb_adr_o}, 32'h0094);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_BEEF;
    tick();
    wb_ack_i = 1'b0;
    chk("post_rst_rdv", {31'b0, avm_readdatavalid}, 32'd1);
    chk("post_rst_data", avm_readdata, 32'h0BAD_BEEF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
